wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Multi-cycle controller that adds two WORDS×N-bit operands by sequencing one instance of the team's N-bit adder, `eight_bit_adder #(.N(N))` (ports `A`, `B`, `ci`, `S`, `co`), one N-bit slice per cycle, least significant slice first. The carry from each slice is registered and fed into the next slice. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area so the datapath keeps a single narrow adder.

## Interface
- `N`, 8, adder slice width in bits; passed to the adder instance.
- `WORDS`, 4, number of slices per operation; must be at least 2. Total width W = N*WORDS.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands this cycle.
- `a`  in  W  operand A; sampled only on the input handshake.
- `b`  in  W  operand B; sampled only on the input handshake.
- `cin`  in  1  carry into the least significant slice; sampled on the input handshake.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  W  result, {slice WORDS-1 … slice 0}.
- `cout`  out  1  carry out of the most significant slice.
- `busy`  out  1  high in RUN and DONE.

## Operation
- Only one clock (`clk`). Reset is synchronous and active-high (`rst`).
- States are IDLE, RUN and DONE.
- IDLE:
  - `in_ready` = 1.
  - When `in_valid & in_ready`: capture `a`, `b` and `cin` into operand shift registers, clear the slice counter, go to RUN.
- RUN:
  - The adder is driven with `A` = op_a[N-1:0], `B` = op_b[N-1:0] and `ci` = carry register.
  - Each cycle, `S` is shifted into the top of the result register and `co` is stored in the carry register.
  - The operand registers shift right by N bits each cycle.
  - After the slice with counter = WORDS-1, the block goes to DONE.
  - The counter is ceil(log2(WORDS)) bits wide and never wraps mid-operation.
- DONE:
  - `out_valid` = 1.
  - `sum` and `cout` are held stable while `out_ready` = 0.
  - When `out_ready` = 1, go to IDLE.
  - `in_ready` = 0 in DONE. There is no same-cycle accept of a new request.
- Arithmetic: {`cout`, `sum`} = a + b + cin, computed modulo 2^(W+1), all unsigned.
- `in_valid` while `busy`: ignored; the request is not lost, because the producer must hold it until `in_ready` rises.
- `out_ready` outside DONE: no effect.
- Reset values: state IDLE, `out_valid` 0, `sum` 0, `cout` 0, `busy` 0, carry register 0, counter 0.
- `in_ready` is 0 during any cycle where `rst` = 1.
- Reset in RUN or DONE abandons the operation. The next cycle is IDLE with all outputs at their reset values, and no partial result is ever presented.

## Timing
- Input handshake at cycle T. RUN occupies cycles T+1 … T+WORDS. `out_valid` rises at T+WORDS+1. That is a latency of 5 cycles for the default WORDS = 4.
- Output handshake at cycle D gives IDLE at D+1, and the next accept is possible at D+1.
- Peak throughput is one operation per WORDS+2 cycles.
- `sum`, `cout`, `out_valid`, `busy` and the state register are driven directly from flops.
- `in_ready` is decoded from state and `rst` only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- Macro: `WIDE_ADD_OVF_EN`.
- Defined:
  - Adds output port `ovf`, `out`, 1 bit, a two's-complement overflow flag.
  - `ovf` = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), computed from the captured operand sign bits.
  - `ovf` is registered with `sum`, valid while `out_valid` = 1, and 0 after reset.
- Undefined:
  - Port `ovf` and its sign-capture flops are absent.
  - Behaviour is otherwise identical.

## Test plan
All scenarios use N = 8, WORDS = 4 (W = 32).
1. Basic add: a=0x00000005, b=0x0000000A, cin=0 → sum=0x0000000F, cout=0; `out_valid` rises exactly 5 cycles after the accept; `busy` is high for those 5 cycles and the DONE cycle(s).
2. Full carry ripple across slices: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1.
3. Signed overflow, with `WIDE_ADD_OVF_EN` defined: a=0x80000000, b=0x80000000, cin=0 → sum=0x00000000, cout=1, ovf=1. A second run with a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1.
4. Backpressure: hold `out_ready`=0 for 3 cycles in DONE → sum/cout stable and `in_ready`=0 throughout. A pending request with `in_valid` held (a=0x12345678, b=0x11111111) is accepted the cycle after the output handshake and yields sum=0x23456789.
5. Reset mid-operation: assert `rst` during the second RUN cycle of a=0xAAAAAAAA, b=0x55555555 → next cycle `out_valid`=0, sum=0, `busy`=0. `in_ready`=1 in the first cycle after `rst` deasserts, and no stale result is ever presented.
6. Back-to-back with `out_ready` tied high and `in_valid` tied high: 10 random operand pairs → each result matches the reference model, and accepts are spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/eight_bit_adder.sv
// eight_bit_adder: the team's N-bit ripple adder slice (purely combinational).
// Ports:
//   A, B : N-bit addends
//   ci   : carry in
//   S    : N-bit sum
//   co   : carry out
module eight_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ci,
  output logic [N-1:0] S,
  output logic         co
);

  assign {co, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, ci};

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two WORDS*N-bit operands by stepping a single
// N-bit adder slice over them, least significant slice first, one slice per
// cycle, with the inter-slice carry held in a register.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin sampled on accept)
//   a, b, cin           : W-bit operands and carry in (W = N*WORDS)
//   out_valid/out_ready : result handshake
//   sum, cout           : W-bit result and carry out of the top slice
//   busy                : high while an operation is running or presented
//   ovf                 : two's-complement overflow flag, only present when
//                         the WIDE_ADD_OVF_EN macro is defined
module wide_add_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               busy
`ifdef WIDE_ADD_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int W     = N * WORDS;
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

`ifdef WIDE_ADD_OVF_EN
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             ovf_q, ovf_d;
`endif

  logic [N-1:0]     add_s;
  logic             add_co;

  eight_bit_adder #(.N(N)) u_slice_adder (
    .A  (op_a_q[N-1:0]),
    .B  (op_b_q[N-1:0]),
    .ci (carry_q),
    .S  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef WIDE_ADD_OVF_EN
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    ovf_d       = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE; reset overrides in the flop block
        if (in_valid) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          busy_d  = 1'b1;
`ifdef WIDE_ADD_OVF_EN
          sign_a_d = a[W-1];
          sign_b_d = b[W-1];
`endif
        end
      end

      S_RUN: begin
        // Slice result enters at the top; after WORDS shifts slice 0 sits
        // at the bottom and the register holds the whole sum in order.
        res_d   = {add_s, res_q[W-1:N]};
        carry_d = add_co;
        op_a_d  = {{N{1'b0}}, op_a_q[W-1:N]};
        op_b_d  = {{N{1'b0}}, op_b_q[W-1:N]};
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
`ifdef WIDE_ADD_OVF_EN
          ovf_d = (sign_a_q == sign_b_q) && (add_s[N-1] != sign_a_q);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef WIDE_ADD_OVF_EN
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  // After the last slice the carry register holds the top slice's carry out
  // and stays put through DONE, so it doubles as cout.
  assign sum       = res_q;
  assign cout      = carry_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = (state_q == S_IDLE) && !rst;
`ifdef WIDE_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=8, WORDS=4).
// A cycle-level behavioural model (latency countdown plus plain 33-bit
// arithmetic) is checked against the DUT on every negative clock edge;
// directed scenarios add hand-computed literal expectations.
module tb_wide_add_sequencer;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef WIDE_ADD_OVF_EN
  logic         ovf;
`endif

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef WIDE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           armed   = 0;
  bit           m_busy  = 0;
  bit           m_valid = 0;
  bit           m_known = 0;
  int           m_wait  = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout;
  logic         p_ovf;
  int           acc_q[$];
  int           vld_cyc = 0;

  always @(negedge clk) begin
    logic [W:0] full;
    if (armed) begin
      check("in_ready", in_ready, !rst && !m_busy);
      check("busy", busy, m_busy);
      check("out_valid", out_valid, m_valid);
      if (m_known) begin
        check("sum", sum, m_sum);
        check("cout", cout, m_cout);
`ifdef WIDE_ADD_OVF_EN
        check("ovf", ovf, m_ovf);
`endif
      end
    end
    // advance the model to what the coming rising edge produces
    if (rst) begin
      armed   = 1;
      m_busy  = 0;
      m_valid = 0;
      m_known = 1;
      m_wait  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (armed) begin
      if (!m_busy) begin
        if (in_valid) begin
          full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          p_sum   = full[W-1:0];
          p_cout  = full[W];
          p_ovf   = (a[W-1] == b[W-1]) && (p_sum[W-1] != a[W-1]);
          m_busy  = 1;
          m_known = 0;
          m_wait  = WORDS;
          acc_q.push_back(cyc);
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1;
          m_known = 1;
          m_sum   = p_sum;
          m_cout  = p_cout;
          m_ovf   = p_ovf;
          vld_cyc = cyc + 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
        m_busy  = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_accept(input bit drop);
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) check("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    @(posedge clk); #1;
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    wait_accept(1);
    wait_valid();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dcyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: basic add and latency
    run_op(32'h00000005, 32'h0000000A, 1'b0);
    check("t1_sum", sum, 32'h0000000F);
    check("t1_cout", cout, 0);
    check("t1_model", m_sum, 32'h0000000F);
    check("t1_latency", vld_cyc - acc_q[acc_q.size()-1], 5);
    check("t1_busy", busy, 1);

    // 2: carry ripples through every slice
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
    check("t2_sum", sum, 32'h00000000);
    check("t2_cout", cout, 1);
    check("t2_model_cout", m_cout, 1);

    // 3: signed overflow cases
    run_op(32'h80000000, 32'h80000000, 1'b0);
    check("t3a_sum", sum, 32'h00000000);
    check("t3a_cout", cout, 1);
`ifdef WIDE_ADD_OVF_EN
    check("t3a_ovf", ovf, 1);
`endif
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    check("t3b_sum", sum, 32'h80000000);
    check("t3b_cout", cout, 0);
`ifdef WIDE_ADD_OVF_EN
    check("t3b_ovf", ovf, 1);
`endif

    // 4: backpressure with a pending request
    @(posedge clk); #1 out_ready = 1'b0;
    run_op(32'h01020304, 32'h10203040, 1'b0);
    @(posedge clk); #1;
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_sum", sum, 32'h11223344);
      check("t4_hold_cout", cout, 0);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    dcyc = cyc;
    wait_accept(1);
    check("t4_accept_cycle", acc_q[acc_q.size()-1], dcyc + 1);
    wait_valid();
    check("t4_sum", sum, 32'h23456789);

    // 5: reset during the second RUN cycle
    @(posedge clk); #1;
    a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b0; in_valid = 1'b1;
    wait_accept(1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid", out_valid, 0);
    check("t5_sum", sum, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_stale", out_valid, 0);
    end

    // 6: back-to-back with in_valid and out_ready held high
    @(posedge clk); #1;
    base = acc_q.size();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      wait_accept(i == 9);
    end
    wait_valid();
    repeat (3) @(posedge clk);
    for (int i = base + 1; i < base + 10; i++)
      check("t6_spacing", acc_q[i] - acc_q[i-1], 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
